// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU, with one registered response slot per requester.
// Define ALU_ARB_FIXED_PRIO_EN to give requester 0 strict priority instead of round-robin.

module alu (
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        negative_o,
  output logic        zero_o
);
  logic [4:0] shamt_s;
  logic       zero_en_s;

  assign shamt_s = b_i[4:0];

  // Opcode decode; compares and undefined ops never report zero.
  always_comb begin
    result_o   = 32'd0;
    negative_o = 1'b0;
    zero_en_s  = 1'b1;
    case (op_i)
      4'd0: result_o = a_i + b_i;
      4'd1: begin
        result_o   = a_i - b_i;
        negative_o = result_o[31];
      end
      4'd2: result_o = a_i | b_i;
      4'd3: result_o = a_i ^ b_i;
      4'd4: result_o = a_i & b_i;
      4'd5: result_o = a_i << shamt_s;
      4'd6: result_o = $unsigned($signed(a_i) >>> shamt_s);
      4'd7: begin
        result_o  = {31'd0, (a_i < b_i)};
        zero_en_s = 1'b0;
      end
      4'd8: begin
        result_o  = {31'd0, ($signed(a_i) < $signed(b_i))};
        zero_en_s = 1'b0;
      end
      4'd9: result_o = a_i >> shamt_s;
      default: begin
        result_o  = 32'd0;
        zero_en_s = 1'b0;
      end
    endcase
    zero_o = zero_en_s && (result_o == 32'd0);
  end
endmodule

module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_negative,
  output logic             rsp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_negative,
  output logic             rsp1_zero
);
  logic             elig0_s, elig1_s, gnt0_s, gnt1_s;
  logic [3:0]       op_s;
  logic [WIDTH-1:0] a_s, b_s, alu_res_s;
  logic             alu_neg_s, alu_zero_s;
  logic             valid0_q, valid0_d, valid1_q, valid1_d;
  logic [WIDTH-1:0] res0_q, res1_q;
  logic             neg0_q, zero0_q, neg1_q, zero1_q;

  assign elig0_s = !valid0_q || rsp0_ready;
  assign elig1_s = !valid1_q || rsp1_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it can use its slot.
  always_comb begin
    req0_ready = elig0_s;
    req1_ready = elig1_s && !(req0_valid && elig0_s);
  end
`else
  logic prio_q, prio_d;

  // Round-robin: the pointer only matters when both sides could be served.
  always_comb begin
    req0_ready = elig0_s && !(req1_valid && elig1_s && prio_q);
    req1_ready = elig1_s && !(req0_valid && elig0_s && !prio_q);
    if (gnt0_s) begin
      prio_d = 1'b1;
    end else if (gnt1_s) begin
      prio_d = 1'b0;
    end else begin
      prio_d = prio_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`endif

  assign gnt0_s = req0_valid && req0_ready;
  assign gnt1_s = req1_valid && req1_ready;

  // Operand mux into the shared ALU; grants are mutually exclusive.
  always_comb begin
    if (gnt1_s) begin
      op_s = req1_op;
      a_s  = req1_a;
      b_s  = req1_b;
    end else begin
      op_s = req0_op;
      a_s  = req0_a;
      b_s  = req0_b;
    end
  end

  alu u_alu (
    .op_i       (op_s),
    .a_i        (a_s),
    .b_i        (b_s),
    .result_o   (alu_res_s),
    .negative_o (alu_neg_s),
    .zero_o     (alu_zero_s)
  );

  // Slot occupancy: capture fills, consume without capture drains.
  always_comb begin
    if (gnt0_s) begin
      valid0_d = 1'b1;
    end else if (rsp0_ready) begin
      valid0_d = 1'b0;
    end else begin
      valid0_d = valid0_q;
    end
    if (gnt1_s) begin
      valid1_d = 1'b1;
    end else if (rsp1_ready) begin
      valid1_d = 1'b0;
    end else begin
      valid1_d = valid1_q;
    end
  end

  // Response slot registers; data only changes on capture.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      res0_q   <= '0;
      res1_q   <= '0;
      neg0_q   <= 1'b0;
      zero0_q  <= 1'b0;
      neg1_q   <= 1'b0;
      zero1_q  <= 1'b0;
    end else begin
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      if (gnt0_s) begin
        res0_q  <= alu_res_s;
        neg0_q  <= alu_neg_s;
        zero0_q <= alu_zero_s;
      end
      if (gnt1_s) begin
        res1_q  <= alu_res_s;
        neg1_q  <= alu_neg_s;
        zero1_q <= alu_zero_s;
      end
    end
  end

  assign rsp0_valid    = valid0_q;
  assign rsp0_result   = res0_q;
  assign rsp0_negative = neg0_q;
  assign rsp0_zero     = zero0_q;
  assign rsp1_valid    = valid1_q;
  assign rsp1_result   = res1_q;
  assign rsp1_negative = neg1_q;
  assign rsp1_zero     = zero1_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected responses queued at grant, compared when the slot presents them.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        nRst;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_negative, rsp0_zero;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_negative, rsp1_zero;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;

  int          n_vec = 0;
  int          n_miss = 0;
  logic [33:0] q0[$];
  logic [33:0] q1[$];
  logic        prio_m;
  int          obs_gnt;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .nRst(nRst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_negative(rsp0_negative), .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_negative(rsp1_negative), .rsp1_zero(rsp1_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference ALU: {negative, zero, result}
  function automatic logic [33:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        n, zv;
    int          sh;
    sh = int'(b[4:0]);
    n  = 1'b0;
    zv = 1'b1;
    case (op)
      4'd0: r = a + b;
      4'd1: begin r = a - b; n = r[31]; end
      4'd2: r = a | b;
      4'd3: r = a ^ b;
      4'd4: r = a & b;
      4'd5: r = a << sh;
      4'd6: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd7: begin r = (a < b) ? 32'd1 : 32'd0; zv = 1'b0; end
      4'd8: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; zv = 1'b0; end
      4'd9: r = a >> sh;
      default: begin r = 32'd0; zv = 1'b0; end
    endcase
    return {n, zv && (r == 32'd0), r};
  endfunction

  // One clock: check outputs and readiness at negedge, update model, return at posedge+1.
  task automatic tick();
    logic e0, e1, x0, x1, g0, g1, r0, r1;
    @(negedge clk);
    e0 = (q0.size() == 0) || rsp0_ready;
    e1 = (q1.size() == 0) || rsp1_ready;
    chk("rsp0_valid", 32'(rsp0_valid), 32'(q0.size() != 0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(q1.size() != 0));
    if (q0.size() != 0) begin
      chk("rsp0_result", rsp0_result, q0[0][31:0]);
      chk("rsp0_flags", {30'd0, rsp0_negative, rsp0_zero}, {30'd0, q0[0][33:32]});
      if (rsp0_ready) void'(q0.pop_front());
    end
    if (q1.size() != 0) begin
      chk("rsp1_result", rsp1_result, q1[0][31:0]);
      chk("rsp1_flags", {30'd0, rsp1_negative, rsp1_zero}, {30'd0, q1[0][33:32]});
      if (rsp1_ready) void'(q1.pop_front());
    end
    x0 = req0_valid && e0;
    x1 = req1_valid && e1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    g0 = x0;
    g1 = x1 && !x0;
    r0 = e0;
    r1 = e1 && !x0;
`else
    if (x0 && x1) begin
      g0 = !prio_m;
      g1 = prio_m;
    end else begin
      g0 = x0;
      g1 = x1;
    end
    r0 = e0 && !(x1 && prio_m);
    r1 = e1 && !(x0 && !prio_m);
`endif
    chk("req0_ready", 32'(req0_ready), 32'(r0));
    chk("req1_ready", 32'(req1_ready), 32'(r1));
    obs_gnt = (req0_valid && req0_ready) ? 0 : ((req1_valid && req1_ready) ? 1 : -1);
    if (g0) q0.push_back(alu_ref(req0_op, req0_a, req0_b));
    if (g1) q1.push_back(alu_ref(req1_op, req1_a, req1_b));
    if (g0) prio_m = 1'b1;
    else if (g1) prio_m = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  typedef struct { logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] res; logic z; } vec_t;
  vec_t dir[5];
  int   exp_gnt[4];

  initial begin
    nRst = 1'b0;
    prio_m = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    set1(1'b0, 4'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    chk("rst_res0", rsp0_result, 32'd0);
    chk("rst_res1", rsp1_result, 32'd0);
    chk("rst_flags", {28'd0, rsp0_negative, rsp0_zero, rsp1_negative, rsp1_zero}, 32'd0);
    @(negedge clk);
    nRst = 1'b1;
    @(posedge clk);
    #1;

    // Reset then a single ADD 5 + -5
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    tick();
    chk("idle_res0", rsp0_result, 32'd0);
    set0(1'b1, 4'd0, 32'd5, -32'sd5);
    tick();
    chk("add_gnt", 32'(obs_gnt), 32'd0);
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    chk("add_valid", 32'(rsp0_valid), 32'd1);
    chk("add_res", rsp0_result, 32'd0);
    chk("add_flags", {30'd0, rsp0_negative, rsp0_zero}, 32'd1);
    tick();

    // Compare, shift and undefined ops
    dir[0] = '{4'd8,  32'hFFFF_FFFF, 32'd1, 32'd1,         1'b0};
    dir[1] = '{4'd7,  32'hFFFF_FFFF, 32'd1, 32'd0,         1'b0};
    dir[2] = '{4'd6,  32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0};
    dir[3] = '{4'd9,  32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0};
    dir[4] = '{4'd12, 32'h1234_5678, 32'd9, 32'd0,         1'b0};
    foreach (dir[i]) begin
      set0(1'b1, dir[i].op, dir[i].a, dir[i].b);
      tick();
      chk($sformatf("dir%0d_res", i), rsp0_result, dir[i].res);
      chk($sformatf("dir%0d_zero", i), 32'(rsp0_zero), 32'(dir[i].z));
    end
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    tick();

    // Reset mid-op: prio is 1 after this accept unless reset clears it
    set0(1'b1, 4'd0, 32'd1, 32'd2);
    tick();
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    nRst = 1'b0;
    #1;
    chk("rst_async_valid", 32'(rsp0_valid), 32'd0);
    q0.delete();
    q1.delete();
    prio_m = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    @(posedge clk);
    #1;
    tick();

    // Contention: both SUB 3-7
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_gnt = '{0, 0, 0, 0};
`else
    exp_gnt = '{0, 1, 0, 1};
`endif
    set0(1'b1, 4'd1, 32'd3, 32'd7);
    set1(1'b1, 4'd1, 32'd3, 32'd7);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr_gnt%0d", i), 32'(obs_gnt), 32'(exp_gnt[i]));
      if (exp_gnt[i] == 0) begin
        chk("rr_res", rsp0_result, 32'hFFFF_FFFC);
        chk("rr_neg", 32'(rsp0_negative), 32'd1);
      end else begin
        chk("rr_res", rsp1_result, 32'hFFFF_FFFC);
        chk("rr_neg", 32'(rsp1_negative), 32'd1);
      end
    end
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    set1(1'b0, 4'd0, 32'd0, 32'd0);
    tick();

    // Backpressure on slot 1
    rsp1_ready = 1'b0;
    set1(1'b1, 4'd5, 32'd1, 32'd33);
    tick();
    for (int i = 0; i < 5; i++) begin
      set0(1'b1, 4'd0, 32'(i * 7), 32'd100);
      tick();
      chk("bp_gnt0", 32'(obs_gnt), 32'd0);
      chk("bp_hold1", rsp1_result, 32'd2);
    end
    chk("bp_ready1", 32'(req1_ready), 32'd0);

    // Same-cycle consume and capture on slot 0
    set1(1'b0, 4'd0, 32'd0, 32'd0);
    set0(1'b1, 4'd3, 32'h0000_00F0, 32'h0000_000F);
    tick();
    chk("cc_gnt", 32'(obs_gnt), 32'd0);
    chk("cc_valid", 32'(rsp0_valid), 32'd1);
    chk("cc_res", rsp0_result, 32'h0000_00FF);
    rsp1_ready = 1'b1;
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    tick();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      set0(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
      set1(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    set1(1'b0, 4'd0, 32'd0, 32'd0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
